data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised byte-addressable data memory for the RISC-V pipeline's MEM stage. It adds RV32 byte, half and word access sizes with sign or zero extension, and a valid/ready request handshake. Reads have a configurable latency. Misaligned and out-of-range accesses are flagged. A post-reset sequential clear replaces a single-cycle array reset. A combinational debug word port is kept for bench inspection.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4, at least 16.
BASE_ADDR, 32'h0000_0000, byte address mapped to array index 0; must be 4-aligned.
RD_LATENCY, 1, cycles from read acceptance to rsp_valid_o; legal range 1..4.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-high (reset is asserted while rst_n=1)
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&ready at posedge
req_we_i  in  1  1=store, 0=load
req_addr_i  in  32  byte address
req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned_i  in  1  loads only: 1 selects zero-extend (lbu/lhu)
req_wdata_i  in  32  store data; low bytes used for byte/half
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned, out-of-range or illegal size; qualified by rsp_valid_o
dbg_addr_i  in  32  debug byte address; bits [1:0] ignored
dbg_data_o  out  32  combinational little-endian word; 0 if out of range

Behaviour:
- Array is DEPTH_BYTES x 8 bits, little-endian. Index = req_addr_i - BASE_ADDR, 32-bit unsigned.
- FSM states: INIT, IDLE, RD_WAIT, RESP.
- Reset asserted: state=INIT, clear counter=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- INIT: zero one 32-bit word per cycle at the clear counter. After DEPTH_BYTES/4 cycles, go to IDLE. Requests are ignored and req_ready_o stays 0 throughout.
- IDLE: req_ready_o=1. On accept, compute err:
  - size=3;
  - size=1 and addr[0]=1;
  - size=2 and addr[1:0]!=0;
  - index+bytes > DEPTH_BYTES.
- Store accept: if no err, write the enabled bytes at that posedge. If err, write nothing. Next cycle: rsp_valid_o=1, rsp_rdata_o=0, rsp_err_o=err. State stays IDLE, so back-to-back stores are accepted every cycle.
- Load accept: capture index, size, unsigned flag and err.
  - RD_LATENCY=1: response in the next cycle, state stays IDLE, back-to-back loads are allowed.
  - RD_LATENCY>1: go to RD_WAIT with a counter, and req_ready_o=0. rsp_valid_o pulses exactly RD_LATENCY cycles after the accept edge, then the state returns to IDLE.
- Load data is sampled from the array in the response cycle. A store accepted in the same edge as a later load is visible to that load (read-after-write, no stale data).
- Extension:
  - byte: signed gives {{24{b[7]}},b}, unsigned gives {24'b0,b};
  - half: the same rule, using bit 15;
  - word: unchanged.
- On err, rsp_rdata_o=0 and the array is unchanged.
- rsp_valid_o is never held for more than 1 cycle. There is no response backpressure; the consumer must always accept.
- Reset asserted mid-operation: any outstanding response is dropped, and the block re-enters INIT and re-clears memory.
- RESP is a transient state used only when RD_LATENCY>1 (the cycle rsp_valid_o=1); it goes to IDLE on the next edge.
- dbg_data_o is purely combinational and reflects writes immediately after the clock edge.

Decomposition:
- Package data_mem_pkg holds:
  - typedef mem_size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_ILL);
  - typedef mem_state_e (INIT, IDLE, RD_WAIT, RESP);
  - function load_extend(word, byte_off, size, unsigned) returning 32 bits.
- One sub-module, mem_byte_array: DEPTH_BYTES storage with a 4-byte write-enable write port, a 4-byte read port and a debug read port.

Test Plan:
- Reset then release -> req_ready_o=0 for 256 cycles (DEPTH_BYTES=1024), then 1; dbg_data_o at addr 0 and 1020 reads 0.
- sw 0x8765_43A1 @8; lb @8 -> 0xFFFF_FFA1; lbu @8 -> 0x0000_00A1; lh @10 -> 0xFFFF_8765; lhu @10 -> 0x0000_8765; lw @8 -> 0x8765_43A1.
- sb 0x55 @9 after the previous word -> dbg_data_o @8 = 0x8765_55A1; no other bytes change.
- lw @6 and lh @3 -> rsp_err_o=1, rsp_rdata_o=0; sw @1022 -> rsp_err_o=1 and memory unchanged; size=3 -> err.
- RD_LATENCY=3: lw @8 -> req_ready_o low for 2 cycles, rsp_valid_o 3 cycles after accept, single pulse. RD_LATENCY=1: back-to-back sw then lw to the same address -> lw returns the new data.
- Assert rst_n=1 while in RD_WAIT -> no rsp_valid_o, INIT re-runs, previously written word reads 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and load-extension helper for the data memory controller
package data_mem_pkg;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_ILL} mem_size_e;
  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RESP} mem_state_e;
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] byte_off,
                                              input mem_size_e size, input logic uns);
    logic [31:0] sh;
    sh = word >> {byte_off, 3'b000};
    return size == SIZE_B ? {{24{sh[7] & ~uns}}, sh[7:0]} :
           size == SIZE_H ? {{16{sh[15] & ~uns}}, sh[15:0]} : word;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_array.sv
// mem_byte_array: word-organised byte storage with per-lane write enables and two async read ports
module mem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WA = $clog2(DEPTH_BYTES) - 2
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [WA-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [WA-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [WA-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);
  logic [31:0] mem [DEPTH_BYTES/4];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage byte/half/word data memory with handshake, read latency and error flagging
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  input  logic [31:0] dbg_addr_i,
  output logic [31:0] dbg_data_o
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int NW = DEPTH_BYTES / 4;
  mem_state_e state;
  mem_size_e size, cap_size;
  logic [31:0] idx, didx, rd_word, dbg_word, sdata, arr_wdata;
  logic [32:0] end_b;
  logic [2:0] nbytes;
  logic [3:0] be, we;
  logic [AW-3:0] clr, waddr, raddr;
  logic [AW-1:0] cap_idx;
  logic [1:0] lat_cnt;
  logic err, acc, cap_uns, cap_err;
  assign size = mem_size_e'(req_size_i);
  assign idx = req_addr_i - BASE_ADDR;
  assign nbytes = size == SIZE_W ? 3'd4 : size == SIZE_H ? 3'd2 : 3'd1;
  assign end_b = {1'b0, idx} + 33'(nbytes);
  assign err = size == SIZE_ILL || (size == SIZE_H && req_addr_i[0]) ||
               (size == SIZE_W && req_addr_i[1:0] != 2'b00) || end_b > 33'(DEPTH_BYTES);
  assign acc = req_valid_i && req_ready_o;
  assign be = size == SIZE_W ? 4'hF : size == SIZE_H ? (idx[1] ? 4'hC : 4'h3) : 4'b0001 << idx[1:0];
  assign sdata = size == SIZE_W ? req_wdata_i : size == SIZE_H ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};
  // the post-reset clear shares the single write port with stores
  assign we = state == INIT ? 4'hF : (acc && req_we_i && !err) ? be : 4'h0;
  assign waddr = state == INIT ? clr : idx[AW-1:2];
  assign arr_wdata = state == INIT ? 32'h0 : sdata;
  assign raddr = state == RD_WAIT ? cap_idx[AW-1:2] : idx[AW-1:2];
  assign didx = dbg_addr_i - BASE_ADDR;
  assign dbg_data_o = didx < 32'(DEPTH_BYTES) ? dbg_word : 32'h0;
  mem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk(clk), .we(we), .waddr(waddr), .wdata(arr_wdata), .raddr(raddr), .rdata(rd_word),
    .dbg_addr(didx[AW-1:2]), .dbg_data(dbg_word)
  );
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= INIT;
      clr <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o <= 1'b0;
      lat_cnt <= 2'd0;
      cap_idx <= '0;
      cap_size <= SIZE_B;
      cap_uns <= 1'b0;
      cap_err <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        INIT: begin
          clr <= clr + 1'b1;
          if (clr == (AW-2)'(NW - 1)) begin
            state <= IDLE;
            req_ready_o <= 1'b1;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd0) begin
            state <= RESP;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_err_o <= cap_err;
            rsp_rdata_o <= cap_err ? 32'h0 : load_extend(rd_word, cap_idx[1:0], cap_size, cap_uns);
          end
        end
        default: begin
          state <= IDLE;
          if (acc) begin
            if (req_we_i || RD_LATENCY == 1) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o <= err;
              rsp_rdata_o <= (req_we_i || err) ? 32'h0 : load_extend(rd_word, idx[1:0], size, req_unsigned_i);
            end else begin
              state <= RD_WAIT;
              req_ready_o <= 1'b0;
              lat_cnt <= 2'(RD_LATENCY - 2);
              cap_idx <= idx[AW-1:0];
              cap_size <= size;
              cap_uns <= req_unsigned_i;
              cap_err <= err;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl with one latency-1 and one latency-3 instance
module tb_data_mem_ctrl;
  logic clk = 0, rst_n = 1;
  logic v1 = 0, v3 = 0, req_we = 0, req_uns = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, dbg_addr = 0;
  logic [1:0] req_size = 0;
  logic ready1, rspv1, err1, ready3, rspv3, err3;
  logic [31:0] rdata1, dbg1, rdata3, dbg3;
  int n_chk = 0, n_pass = 0, cnt;
  always #5 clk = ~clk;
  data_mem_ctrl #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v1), .req_ready_o(ready1), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rspv1), .rsp_rdata_o(rdata1), .rsp_err_o(err1), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg1)
  );
  data_mem_ctrl #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v3), .req_ready_o(ready3), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rspv3), .rsp_rdata_o(rdata3), .rsp_err_o(err3), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask
  task automatic set_req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    req_we = w; req_addr = a; req_size = sz; req_uns = u; req_wdata = wd;
  endtask
  task automatic xfer(input bit l3, input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, input string tag, input logic [31:0] ed, input logic ee);
    @(negedge clk);
    set_req(w, a, sz, u, wd);
    if (l3) v3 = 1; else v1 = 1;
    @(negedge clk);
    v1 = 0; v3 = 0;
    check({tag, ".valid"}, 32'(l3 ? rspv3 : rspv1), 1);
    check({tag, ".data"}, l3 ? rdata3 : rdata1, ed);
    check({tag, ".err"}, 32'(l3 ? err3 : err1), 32'(ee));
  endtask
  task automatic wait_init(input string tag);
    cnt = 0;
    while (!ready1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, ".init_cycles"}, cnt, 256);
    check({tag, ".ready3"}, 32'(ready3), 1);
  endtask
  task automatic dbg_chk(input bit l3, input logic [31:0] a, input string tag, input logic [31:0] exp);
    dbg_addr = a;
    #1 check(tag, l3 ? dbg3 : dbg1, exp);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(ready1), 0);
    check("rst.valid", 32'(rspv1), 0);
    check("rst.rdata", rdata1, 0);
    check("rst.err", 32'(err1), 0);
    rst_n = 0;
    wait_init("init");
    dbg_chk(0, 0, "dbg0", 0);
    dbg_chk(0, 1020, "dbg1020", 0);
    xfer(0, 1, 8, 2, 0, 32'h8765_43A1, "sw8", 0, 0);
    xfer(0, 0, 8, 0, 0, 0, "lb8", 32'hFFFF_FFA1, 0);
    xfer(0, 0, 8, 0, 1, 0, "lbu8", 32'h0000_00A1, 0);
    xfer(0, 0, 10, 1, 0, 0, "lh10", 32'hFFFF_8765, 0);
    xfer(0, 0, 10, 1, 1, 0, "lhu10", 32'h0000_8765, 0);
    xfer(0, 0, 8, 2, 0, 0, "lw8", 32'h8765_43A1, 0);
    xfer(0, 1, 9, 0, 0, 32'hFFFF_FF55, "sb9", 0, 0);
    dbg_chk(0, 11, "dbg8_after_sb", 32'h8765_55A1);
    dbg_chk(0, 4, "dbg4", 0);
    dbg_chk(0, 12, "dbg12", 0);
    xfer(0, 0, 9, 0, 1, 0, "lbu9", 32'h55, 0);
    xfer(0, 0, 6, 2, 0, 0, "lw6", 0, 1);
    xfer(0, 0, 3, 1, 0, 0, "lh3", 0, 1);
    xfer(0, 1, 1022, 2, 0, 32'hFFFF_FFFF, "sw1022", 0, 1);
    xfer(0, 1, 1022, 1, 0, 32'hFFFF_BEEF, "sh1022", 0, 0);
    dbg_chk(0, 1020, "dbg1020_after", 32'hBEEF_0000);
    xfer(0, 0, 1024, 2, 0, 0, "lw1024", 0, 1);
    xfer(0, 0, 1023, 0, 0, 0, "lb1023", 32'hFFFF_FFBE, 0);
    xfer(0, 0, 0, 3, 0, 0, "size3", 0, 1);
    xfer(0, 1, 8, 3, 0, 32'h1111_1111, "size3_store", 0, 1);
    dbg_chk(0, 8, "dbg8_after_ill", 32'h8765_55A1);
    dbg_chk(0, 2048, "dbg_oor", 0);
    @(negedge clk);
    set_req(1, 16, 2, 0, 32'hDEAD_BEEF);
    v1 = 1;
    @(negedge clk);
    check("b2b.sw.valid", 32'(rspv1), 1);
    check("b2b.ready", 32'(ready1), 1);
    set_req(0, 16, 2, 0, 0);
    @(negedge clk);
    v1 = 0;
    check("b2b.lw.valid", 32'(rspv1), 1);
    check("b2b.lw.data", rdata1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("b2b.idle", 32'(rspv1), 0);
    xfer(1, 1, 8, 2, 0, 32'h1234_5678, "l3.sw8", 0, 0);
    @(negedge clk);
    set_req(0, 8, 2, 0, 0);
    v3 = 1;
    @(negedge clk);
    v3 = 0;
    check("l3.c1.ready", 32'(ready3), 0);
    check("l3.c1.valid", 32'(rspv3), 0);
    @(negedge clk);
    check("l3.c2.ready", 32'(ready3), 0);
    check("l3.c2.valid", 32'(rspv3), 0);
    @(negedge clk);
    check("l3.c3.valid", 32'(rspv3), 1);
    check("l3.c3.data", rdata3, 32'h1234_5678);
    check("l3.c3.err", 32'(err3), 0);
    @(negedge clk);
    check("l3.c4.valid", 32'(rspv3), 0);
    check("l3.c4.ready", 32'(ready3), 1);
    @(negedge clk);
    set_req(0, 8, 2, 0, 0);
    v3 = 1;
    @(negedge clk);
    v3 = 0;
    check("rdw.ready", 32'(ready3), 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rdw.valid_in_reset", 32'(rspv3), 0);
    end
    rst_n = 0;
    wait_init("reinit");
    dbg_chk(1, 8, "reinit.dbg3", 0);
    dbg_chk(0, 16, "reinit.dbg1", 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
